// File: rtl/aasd_counter.sv
// Purpose : WIDTH-bit up-counter with synchronous load and count enable, reset through an AASD synchronizer.
// Latency : load/increment visible one clock-to-q after the sampling edge; first change is edge SYNC_STAGES+1 after reset release.
// Backpr. : none; Load and Enable are sampled every rising edge, and Load takes priority over Enable.
//
// Ports:
//   Clock  - system clock, rising edge active
//   Reset  - asynchronous active-low external reset
//   Enable - increment Count when high and Load low
//   Load   - load Data into Count (priority over Enable)
//   Data   - parallel load value
//   Count  - registered counter value
module aasd_counter #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] Count
);

  // Reset synchronizer: every stage clears asynchronously on Reset low.
  // After release, a 1 ripples in from stage 0, so the last stage goes high
  // on the SYNC_STAGES-th rising edge, aligned to Clock.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync_n;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_sync_n = r_sync[SYNC_STAGES-1];

  // Counter register. Its async clear follows the synchronized reset, which
  // falls immediately with Reset but rises only on a clock edge. The edge that
  // releases w_rst_sync_n still sees it low, so counting starts one edge later.
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_one;

  assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge Clock or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= Data;
    end else if (Enable) begin
      r_count <= r_count + w_one;  // wraps modulo 2^WIDTH
    end
  end

  assign Count = r_count;

endmodule

// File: tb/tb_aasd_counter.sv
module tb_aasd_counter;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic       Load;
  logic [5:0] Data;
  logic [5:0] Count;

  int n_checks;
  int n_fail;

  aasd_counter #(.WIDTH(6), .SYNC_STAGES(2)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Load   (Load),
    .Data   (Data),
    .Count  (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] expected);
    n_checks++;
    assert (Count === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, Count, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Enable   = 1'b0;
    Load     = 1'b0;
    Data     = 6'd0;

    // Async assertion mid-cycle, no edge needed.
    #12;
    Reset = 1'b0;
    #1;
    check("async_clear", 6'd0);
    Enable = 1'b1;
    tick();
    check("held_in_reset", 6'd0);

    // Release with Enable=1: edges 1 and 2 keep 0, edge 3 gives 1.
    Reset = 1'b1;
    tick(); check("release_e1", 6'd0);
    tick(); check("release_e2", 6'd0);
    tick(); check("release_e3", 6'd1);
    tick(); check("count_2", 6'd2);
    tick(); check("count_3", 6'd3);

    // Hold for 4 edges.
    Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("hold", 6'd3);
    end

    // Load 0, then count 7 edges.
    Load = 1'b1; Data = 6'd0;
    tick(); check("load_zero", 6'd0);
    Load = 1'b0; Enable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      Data = 6'(i * 9);  // ignored while Load=0
      tick(); check("count_up", 6'(i));
    end

    // Load 60 and wrap through 63 -> 0.
    Load = 1'b1; Data = 6'd60;
    tick(); check("load_60", 6'd60);
    Load = 1'b0; Data = 6'd5;
    tick(); check("wrap_61", 6'd61);
    tick(); check("wrap_62", 6'd62);
    tick(); check("wrap_63", 6'd63);
    tick(); check("wrap_0", 6'd0);
    tick(); check("wrap_1", 6'd1);

    // Load beats Enable.
    Load = 1'b1; Enable = 1'b1; Data = 6'd42;
    tick(); check("load_prio", 6'd42);
    tick(); check("load_prio_hold1", 6'd42);
    tick(); check("load_prio_hold2", 6'd42);

    // Reset with Load still high.
    #3;
    Reset = 1'b0;
    #1;
    check("reset_over_load", 6'd0);
    tick(); check("reset_over_load_edge", 6'd0);
    Reset = 1'b1;
    tick(); check("load_release_e1", 6'd0);
    tick(); check("load_release_e2", 6'd0);
    tick(); check("load_release_e3", 6'd42);

    // Reset pulse of one period while counting.
    Load = 1'b0; Enable = 1'b1;
    tick(); check("inc_43", 6'd43);
    tick(); check("inc_44", 6'd44);
    Reset = 1'b0;
    #1;
    check("pulse_clear", 6'd0);
    #9;
    check("pulse_after_edge", 6'd0);
    Reset = 1'b1;
    tick(); check("pulse_release_e1", 6'd0);
    tick(); check("pulse_release_e2", 6'd0);
    tick(); check("pulse_release_e3", 6'd1);
    tick(); check("pulse_resume_2", 6'd2);

    // Sub-period glitch on Reset between edges.
    #2;
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("glitch_clear", 6'd0);
    tick(); check("glitch_e1", 6'd0);
    tick(); check("glitch_e2", 6'd0);
    tick(); check("glitch_e3", 6'd1);

    // Load while disabled.
    Enable = 1'b0; Load = 1'b1; Data = 6'd36;
    tick(); check("load_dis_36", 6'd36);
    tick(); check("load_dis_hold", 6'd36);
    Load = 1'b0; Data = 6'd11;
    tick(); check("data_ignored", 6'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aasd_counter.md
Name: aasd_counter

Overview:
- Top-level 6-bit up-counter with synchronous parallel load and count enable.
- Its reset is conditioned by an on-chip AASD (asynchronous-assert, synchronous-deassert) reset synchronizer.
- Counter clears immediately when reset asserts; release is aligned to Clock so the counter never leaves reset on a partial cycle.
- Used as a standalone counter block; also serves as the reference AASD usage example.

Parameters:
- WIDTH, 6, bit width of Data and Count.
- SYNC_STAGES, 2, number of flops in the reset-deassertion synchronizer (minimum 2).

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low external reset.
- Enable  input  1  count enable; increments Count when high and Load low.
- Load  input  1  synchronous parallel load; takes priority over Enable.
- Data  input  WIDTH  value loaded into Count when Load is high.
- Count  output  WIDTH  registered counter value.

Behaviour:
- One clock, Clock. Reset is asynchronous and active-low: Reset=0 asserts reset.
- AASD synchronizer:
  - SYNC_STAGES flops, all asynchronously cleared to 0 while Reset=0.
  - First stage D input tied to 1. Synchronized reset rst_sync_n is the last stage output.
  - Assertion: Reset falling forces rst_sync_n=0 immediately, with no clock required.
  - Deassertion: after Reset rises, rst_sync_n goes 1 on the SYNC_STAGES-th rising Clock edge.
- Counter register:
  - Asynchronously cleared to 0 while rst_sync_n=0. Reset value of Count = 0.
  - On each rising Clock edge with rst_sync_n=1, priority is:
    1. Load=1: Count <= Data, regardless of Enable.
    2. Else Enable=1: Count <= Count+1, modulo 2^WIDTH (63 -> 0, no carry-out, no saturation).
    3. Else: Count holds.
- Latency:
  - Load and increment take effect on the same rising edge they are sampled; Count is valid after clock-to-q.
  - After Reset rises, the first edge that can change Count is rising edge number SYNC_STAGES+1. With the default, Count first changes on the 3rd rising edge after release.
- Reset mid-operation: Count goes to 0 asynchronously, mid-cycle if necessary. This overrides Load and Enable at any time.
- Reset pulses shorter than a clock period still clear Count and restart the synchronizer.
- Load and Enable both high: load wins. Count equals Data after the edge, not Data+1.
- Data is sampled only at edges where Load=1; Data changes at other times have no effect.
- All inputs except Reset are synchronous and must meet setup/hold to Clock.
- Before the first Reset assertion, Count is undefined and is not checked.

Test Plan:
- Async reset/AASD: Reset 1->0 mid-cycle -> Count=0 before the next edge. Release Reset with Enable=1 -> Count stays 0 on release edges 1 and 2, becomes 1 on edge 3, then 2, 3, ...
- Enable/hold: Enable=0, Load=0 for 4 edges -> Count holds. Enable=1 for 7 edges from 0 -> Count=7.
- Load and wrap: Count=7, Load=1, Data=60 -> Count=60. Then Load=0, Enable=1 -> 61, 62, 63, 0, 1, ... (wrap at 64).
- Load priority: Load=1, Enable=1, Data=42 -> Count=42 and stays 42 while held. Assert Reset=0 with Load still 1 -> Count=0 immediately and stays 0 until 3 edges after release.
- Reset overrides increment: counting with Enable=1, pulse Reset=0 for one period -> Count=0 at once, resumes 1, 2, ... starting from the 3rd edge after release.
- Load while disabled: Enable=0, Load=1, Data=36 -> Count=36 after the first effective edge, holds 36 while Load=1.
